// File: rtl/traffic_state_machine.sv
// Two-road traffic-light controller: free-running timed FSM cycling main/cross green, yellow, all-red.
// Latency: lamp outputs are registered and change on the clock edge that enters a new state.
// No backpressure: free-running with no handshakes; async reset forces all-red at once.
module traffic_state_machine #(
  parameter int MAIN_GREEN_T  = 20,
  parameter int CROSS_GREEN_T = 10,
  parameter int YELLOW_T      = 3,
  parameter int ALL_RED_T     = 2
) (
  input  logic       iClk,
  input  logic       iRstN,
  output logic [2:0] main_st,
  output logic [2:0] cross_st
);

  // One-hot lamp encodings shared by both roads.
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  // Counter reload values: a state of duration D counts D-1 down to 0.
  localparam logic [7:0] MG_LD = 8'(MAIN_GREEN_T - 1);
  localparam logic [7:0] CG_LD = 8'(CROSS_GREEN_T - 1);
  localparam logic [7:0] Y_LD  = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_LD = 8'(ALL_RED_T - 1);

  typedef enum logic [2:0] {
    MAIN_GREEN   = 3'd0,
    MAIN_YELLOW  = 3'd1,
    ALL_RED_A    = 3'd2,
    CROSS_GREEN  = 3'd3,
    CROSS_YELLOW = 3'd4,
    ALL_RED_B    = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  // Successor in the fixed cycle; any stray encoding recovers through ALL_RED_B.
  function automatic state_t succ(input state_t s);
    state_t r;
    case (s)
      MAIN_GREEN:   r = MAIN_YELLOW;
      MAIN_YELLOW:  r = ALL_RED_A;
      ALL_RED_A:    r = CROSS_GREEN;
      CROSS_GREEN:  r = CROSS_YELLOW;
      CROSS_YELLOW: r = ALL_RED_B;
      ALL_RED_B:    r = MAIN_GREEN;
      default:      r = ALL_RED_B;
    endcase
    return r;
  endfunction

  // Counter value loaded on entry to a state.
  function automatic logic [7:0] dwell_ld(input state_t s);
    logic [7:0] r;
    case (s)
      MAIN_GREEN:   r = MG_LD;
      MAIN_YELLOW:  r = Y_LD;
      CROSS_GREEN:  r = CG_LD;
      CROSS_YELLOW: r = Y_LD;
      default:      r = AR_LD;
    endcase
    return r;
  endfunction

  // Lamp decode {main, cross}; anything not explicitly a go/caution state shows all-red.
  function automatic logic [5:0] lamps(input state_t s);
    logic [5:0] r;
    case (s)
      MAIN_GREEN:   r = {LAMP_G, LAMP_R};
      MAIN_YELLOW:  r = {LAMP_Y, LAMP_R};
      CROSS_GREEN:  r = {LAMP_R, LAMP_G};
      CROSS_YELLOW: r = {LAMP_R, LAMP_Y};
      default:      r = {LAMP_R, LAMP_R};
    endcase
    return r;
  endfunction

  // Next-state/counter: advance and reload when the dwell expires, else count down.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MAIN_GREEN, MAIN_YELLOW, ALL_RED_A,
      CROSS_GREEN, CROSS_YELLOW, ALL_RED_B: begin
        if (cnt == 8'd0) begin
          state_nxt = succ(state);
          cnt_nxt   = dwell_ld(succ(state));
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = ALL_RED_B;
        cnt_nxt   = AR_LD;
      end
    endcase
  end

  // State, counter and registered lamp outputs; reset aborts any phase straight to all-red.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state    <= ALL_RED_B;
      cnt      <= AR_LD;
      main_st  <= LAMP_R;
      cross_st <= LAMP_R;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      {main_st, cross_st} <= lamps(state_nxt);
    end
  end

endmodule

// File: tb/tb_traffic_state_machine.sv
// Bench for traffic_state_machine: default and all-ones parameter instances checked every cycle.
// Model computes lamps from the position within the period since main-green entry.
// Directed scenarios: reset hold, full sequence, long run, mid-green and cross-yellow resets.
module tb_traffic_state_machine;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk;
  logic       rst_n;
  logic       rst1_n;
  logic [2:0] main_st, cross_st;
  logic [2:0] main1_st, cross1_st;

  int tests = 0;
  int fails = 0;
  int k  = 0;   // rising edges since release, default instance
  int k1 = 0;   // rising edges since release, all-ones instance

  traffic_state_machine dut (
    .iClk(clk), .iRstN(rst_n), .main_st(main_st), .cross_st(cross_st)
  );

  traffic_state_machine #(
    .MAIN_GREEN_T(1), .CROSS_GREEN_T(1), .YELLOW_T(1), .ALL_RED_T(1)
  ) dut1 (
    .iClk(clk), .iRstN(rst1_n), .main_st(main1_st), .cross_st(cross1_st)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0; else k <= k + 1;

  always @(posedge clk or negedge rst1_n)
    if (!rst1_n) k1 <= 0; else k1 <= k1 + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Schedule model: main green starts at edge ar; then green/yellow/red phases by offset.
  function automatic logic [5:0] model(input int kk, input int mg, input int cg,
                                       input int y, input int ar);
    logic [2:0] m, c;
    int o, p;
    m = R;
    c = R;
    if (kk >= ar) begin
      o = kk - ar;
      p = o % (mg + cg + 2 * y + 2 * ar);
      if (p < mg)                        m = G;
      else if (p < mg + y)               m = Y;
      else if (p < mg + y + ar)          m = R;
      else if (p < mg + y + ar + cg)     c = G;
      else if (p < mg + 2 * y + ar + cg) c = Y;
    end
    return {m, c};
  endfunction

  // Per-cycle compare against the model plus the safety invariants, both instances.
  always @(negedge clk) begin
    logic [5:0] e, e1;
    e  = model(k, 20, 10, 3, 2);
    e1 = model(k1, 1, 1, 1, 1);
    chk("model_main",  int'(main_st),   int'(e[5:3]));
    chk("model_cross", int'(cross_st),  int'(e[2:0]));
    chk("model1_main", int'(main1_st),  int'(e1[5:3]));
    chk("model1_cross", int'(cross1_st), int'(e1[2:0]));
    chk("inv_onehot", int'($onehot(main_st) && $onehot(cross_st) &&
                           $onehot(main1_st) && $onehot(cross1_st)), 1);
    chk("inv_one_red", int'((main_st == R || cross_st == R) &&
                            (main1_st == R || cross1_st == R)), 1);
  end

  // Hand-computed expectations for the default instance, edge i after release.
  task automatic pins(input int i);
    case (i)
      1:  begin chk("pin1_m", int'(main_st), int'(R));  chk("pin1_c", int'(cross_st), int'(R)); end
      2:  begin chk("pin2_m", int'(main_st), int'(G));  chk("pin2_c", int'(cross_st), int'(R)); end
      21: chk("pin21_m", int'(main_st), int'(G));
      22: chk("pin22_m", int'(main_st), int'(Y));
      24: chk("pin24_m", int'(main_st), int'(Y));
      25: begin chk("pin25_m", int'(main_st), int'(R)); chk("pin25_c", int'(cross_st), int'(R)); end
      26: chk("pin26_c", int'(cross_st), int'(R));
      27: begin chk("pin27_m", int'(main_st), int'(R)); chk("pin27_c", int'(cross_st), int'(G)); end
      36: chk("pin36_c", int'(cross_st), int'(G));
      37: chk("pin37_c", int'(cross_st), int'(Y));
      39: chk("pin39_c", int'(cross_st), int'(Y));
      40: begin chk("pin40_m", int'(main_st), int'(R)); chk("pin40_c", int'(cross_st), int'(R)); end
      41: chk("pin41_m", int'(main_st), int'(R));
      42: begin chk("pin42_m", int'(main_st), int'(G)); chk("pin42_c", int'(cross_st), int'(R)); end
      default: ;
    endcase
  endtask

  logic [2:0] exp1_m [6];
  logic [2:0] exp1_c [6];

  initial begin
    int mg_cnt, cg_cnt, first, n;
    exp1_m = '{G, Y, R, R, R, R};
    exp1_c = '{R, R, R, G, Y, R};

    // Reset hold over two edges.
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_m", int'(main_st), int'(R));
    chk("rst_hold_c", int'(cross_st), int'(R));
    chk("rst_hold1_m", int'(main1_st), int'(R));
    rst_n  = 1'b1;
    rst1_n = 1'b1;

    // Full sequence, long run and per-period green counts.
    mg_cnt = 0;
    cg_cnt = 0;
    for (int i = 1; i <= 101; i++) begin
      @(negedge clk);
      pins(i);
      if (i <= 6) begin
        chk("ones_m", int'(main1_st), int'(exp1_m[i-1]));
        chk("ones_c", int'(cross1_st), int'(exp1_c[i-1]));
      end
      if (i >= 2 && i <= 41) begin
        if (main_st == G) mg_cnt++;
        if (cross_st == G) cg_cnt++;
      end
      if (i == 41) begin
        chk("period_main_green", mg_cnt, 20);
        chk("period_cross_green", cg_cnt, 10);
        mg_cnt = 0;
        cg_cnt = 0;
      end
      if (i >= 42 && i <= 81) begin
        if (main_st == G) mg_cnt++;
        if (cross_st == G) cg_cnt++;
      end
    end
    chk("period2_main_green", mg_cnt, 20);
    chk("period2_cross_green", cg_cnt, 10);

    // Mid-green reset at main-green cycle 7 (edge 8 within a period).
    n = 0;
    while ((k % 40) != 8 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("reach_green7", int'(main_st == G && (k % 40) == 8), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_green_m", int'(main_st), int'(R));
    chk("async_rst_green_c", int'(cross_st), int'(R));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_held_m", int'(main_st), int'(R));
    rst_n = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      pins(i);
    end

    // Reset during cross yellow; main must go green before cross.
    n = 0;
    while (cross_st != Y && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("reach_cross_yellow", int'(cross_st), int'(Y));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cy_m", int'(main_st), int'(R));
    chk("async_rst_cy_c", int'(cross_st), int'(R));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    for (int i = 0; i < 60 && first == 0; i++) begin
      @(negedge clk);
      if (main_st == G) first = 1;
      else if (cross_st == G) first = 2;
    end
    chk("main_green_first", first, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
